fpga_slave_fifo: RTL

Parametrised FPGA-side receive buffer between the front-end data path and the ARM host. Parallel words arrive on a write strobe and are queued in a DEPTH-entry FIFO. The ARM pulls them out one word at a time, MSB first, over a serial line clocked by the host's `sclk`. Nibble commands drive the block: read, status and clear. This generalises the fixed-width single-register slave to configurable width and depth, with flow status and overflow reporting.

---
 rtl/fpga_slave_pkg.sv | 13 +
 rtl/fpga_slave_fifo_fifo.sv | 84 ++++++++
 rtl/fpga_slave_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fpga_slave_pkg.sv
// Shared command codes and FSM state type for the FPGA slave receive buffer.
package fpga_slave_pkg;

  localparam logic [3:0] CMD_READ   = 4'b0001;
  localparam logic [3:0] CMD_STATUS = 4'b0110;
  localparam logic [3:0] CMD_CLEAR  = 4'b1100;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

endpackage

// File: rtl/fpga_slave_fifo_fifo.sv
// Synchronous DEPTH-entry FIFO with clear, used as the receive queue.
// DEPTH need not be a power of two; the pointers wrap explicitly.
module slave_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              drop_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              doPop;
  logic              doPush;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept
  // when it coincides with a pop; clear overrides both and never flags a drop.
  assign doPop  = pop_i & ~empty_o & ~clear_i;
  assign doPush = push_i & ~clear_i & (~full_o | doPop);
  assign drop_o = push_i & ~clear_i & full_o & ~doPop;

  // Next pointer and occupancy values.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (doPop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (doPush) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        count_d = count_q + CNT_W'(1);
      end else if (doPop && !doPush) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset, so it has none.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fpga_slave_fifo.sv
// FPGA-side receive buffer: queues parallel words and serialises them MSB
// first to the ARM host on its sclk, with read/status/clear commands.
import fpga_slave_pkg::*;

module fpga_slave_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              in_enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  from_ARM,
  output logic              to_ARM,
  output logic              out_enable,
  output logic [DATA_W-1:0] out_data,
  output logic              dirty,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_enable_q, out_enable_d;
  logic              overflow_q, overflow_d;
  logic              sclk_q;

  logic              sclkRise;
  logic              fifoPop;
  logic              fifoClear;
  logic [DATA_W-1:0] fifoRdata;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              fifoDrop;
  logic [DATA_W-2:0] countExt;

  slave_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_enable),
    .pop_i   (fifoPop),
    .clear_i (fifoClear),
    .wdata_i (in_data),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount),
    .drop_o  (fifoDrop)
  );

  // Only rising sclk edges seen while shifting advance the frame; a level
  // already high when the frame starts is not an edge since sclk_q tracks it.
  assign sclkRise = sclk & ~sclk_q;

  assign to_ARM     = (state_q == ST_SHIFT) & shreg_q[DATA_W-1];
  assign busy       = (state_q == ST_SHIFT);
  assign out_enable = out_enable_q;
  assign out_data   = out_data_q;
  assign dirty      = ~fifoEmpty;
  assign overflow   = overflow_q;

  // Status payload is the occupancy widened to fill the bits below overflow.
  always_comb begin
    countExt = '0;
    countExt[CNT_W-1:0] = fifoCount;
  end

  // Command decode in IDLE and frame shifting in SHIFT.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    out_data_d   = out_data_q;
    out_enable_d = 1'b0;
    fifoPop      = 1'b0;
    fifoClear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (from_ARM == CMD_READ) begin
            state_d  = ST_SHIFT;
            bitcnt_d = '0;
            if (!fifoEmpty) begin
              fifoPop      = 1'b1;
              shreg_d      = fifoRdata;
              out_data_d   = fifoRdata;
              out_enable_d = 1'b1;
            end else begin
              shreg_d = '0;
            end
          end else if (from_ARM == CMD_STATUS) begin
            state_d  = ST_SHIFT;
            bitcnt_d = '0;
            shreg_d  = {overflow_q, countExt};
          end else if (from_ARM == CMD_CLEAR) begin
            fifoClear = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (sclkRise) begin
          shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow: set by a dropped push, cleared only by CLEAR or reset.
  always_comb begin
    overflow_d = overflow_q | fifoDrop;
    if (fifoClear) begin
      overflow_d = 1'b0;
    end
  end

  // State, shift register and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      out_data_q   <= '0;
      out_enable_q <= 1'b0;
      overflow_q   <= 1'b0;
      sclk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      out_data_q   <= out_data_d;
      out_enable_q <= out_enable_d;
      overflow_q   <= overflow_d;
      sclk_q       <= sclk;
    end
  end

endmodule
